// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite single-port SRAM slave.
// Address phase is decoded and latched on acceptance; the data phase performs
// the byte/halfword/word access against an internal word array, optionally
// stretched by a fixed number of wait states. Illegal transfers get the
// two-cycle ERROR response and never touch memory.
module ahb3lite_sram_slave #(
    parameter int HADDR_SIZE  = 16,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int AW = $clog2(MEM_DEPTH);
    // One past the last valid byte address; one extra bit so a memory that
    // fills the whole address space never flags anything as out of range.
    localparam logic [HADDR_SIZE:0] ADDR_LIMIT = (HADDR_SIZE + 1)'(4 * MEM_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    // An accepted, legal transfer whose data phase has not yet completed.
    logic            dph_q, dph_d;
    logic [AW-1:0]   idx_q;
    logic [1:0]      off_q;
    logic [1:0]      size_q;
    logic            wr_q;

    logic            hready_int;
    logic            hresp_int;
    logic            accept;
    logic            addr_err;
    logic            wr_en;
    logic            rd_phase;
    logic [3:0]      be;

    logic [31:0]     mem [MEM_DEPTH];

    // Burst type, protection and the SEQ/NONSEQ distinction carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

    // Only sample an address phase while this slave itself is ready, so a
    // misbehaving HREADY can never cause a second acceptance mid data phase.
    assign accept = HSEL & HREADY & HTRANS[1] & hready_int;

    // Illegal size, misalignment or an address beyond the array.
    always_comb begin
        addr_err = 1'b0;
        if (HSIZE > 3'd2)                               addr_err = 1'b1;
        if ((HSIZE == 3'd1) && HADDR[0])                addr_err = 1'b1;
        if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))   addr_err = 1'b1;
        if ({1'b0, HADDR} >= ADDR_LIMIT)                addr_err = 1'b1;
    end

    // Next-state, wait counter and response outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dph_d      = dph_q;
        hready_int = 1'b1;
        hresp_int  = 1'b0;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                hresp_int = (state_q == ST_ERR2);
                // Any pending data phase completes in this ready cycle.
                dph_d   = 1'b0;
                state_d = ST_IDLE;
                if (accept) begin
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else begin
                        dph_d = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_d = ST_WAIT;
                            cnt_d   = 4'(WAIT_STATES);
                        end
                    end
                end
            end
            ST_WAIT: begin
                hready_int = 1'b0;
                cnt_d      = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_IDLE;
            end
            ST_ERR1: begin
                hready_int = 1'b0;
                hresp_int  = 1'b1;
                state_d    = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and pending-phase registers; reset drops any pending write.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            dph_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dph_q   <= dph_d;
        end
    end

    // Address-phase capture for the following data phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            idx_q  <= '0;
            off_q  <= 2'b00;
            size_q <= 2'b00;
            wr_q   <= 1'b0;
        end else if (accept) begin
            idx_q  <= HADDR[AW+1:2];
            off_q  <= HADDR[1:0];
            size_q <= HSIZE[1:0];
            wr_q   <= HWRITE;
        end
    end

    // Byte-lane enables from the latched size and offset.
    always_comb begin
        be = 4'b0000;
        case (size_q)
            2'd0:    be = 4'b0001 << off_q;
            2'd1:    be = 4'b0011 << off_q;
            default: be = 4'b1111;
        endcase
    end

    // The completing OKAY cycle is the IDLE-state cycle with a pending phase.
    assign wr_en    = dph_q & wr_q & (state_q == ST_IDLE);
    assign rd_phase = dph_q & ~wr_q & (state_q == ST_IDLE);

    // Memory array write port; contents are intentionally not reset.
    always_ff @(posedge HCLK) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && be[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
        end
    end

    // Asynchronous read: a write committed on the previous edge is already
    // visible to a read whose data phase follows it directly.
    assign HRDATA    = rd_phase ? mem[idx_q] : '0;
    assign HREADYOUT = hready_int;
    assign HRESP     = hresp_int;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Bench for ahb3lite_sram_slave: two instances (0 and 3 wait states) on a
// simple single-master bus; expected responses are queued at acceptance and
// scored when each data phase completes.
module tb_ahb3lite_sram_slave;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [15:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        hsel0, hsel3;
    logic        rdy0, rdy3, resp0, resp3;
    logic [31:0] rdata0, rdata3;

    always #5 HCLK = ~HCLK;

    ahb3lite_sram_slave #(.HADDR_SIZE(16), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(HADDR), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'b000), .HPROT(4'b0011), .HTRANS(HTRANS),
        .HREADY(rdy0), .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0)
    );

    ahb3lite_sram_slave #(.HADDR_SIZE(16), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_dut3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel3), .HADDR(HADDR), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'b000), .HPROT(4'b0011), .HTRANS(HTRANS),
        .HREADY(rdy3), .HRDATA(rdata3), .HREADYOUT(rdy3), .HRESP(resp3)
    );

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        resp;
        int          lows;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mdl [2][256];
    int          total = 0;
    int          bad   = 0;
    int          cd    = 0;   // 0 -> u_dut0, 1 -> u_dut3

    function automatic logic c_rdy();
        return (cd == 0) ? rdy0 : rdy3;
    endfunction
    function automatic logic c_resp();
        return (cd == 0) ? resp0 : resp3;
    endfunction
    function automatic logic [31:0] c_rdata();
        return (cd == 0) ? rdata0 : rdata3;
    endfunction

    // Advance to the next ready edge, scoring the data phase that ends there.
    task automatic step();
        int   lows  = 0;
        int   guard = 0;
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (c_rdy()) break;
            lows++;
            if (sbq.size() > 0) begin
                total++;
                if (c_resp() !== sbq[0].resp) begin
                    bad++;
                    $display("FAIL %s resp_low got=%b want=%b", sbq[0].name, c_resp(), sbq[0].resp);
                end
            end
            guard++;
            if (guard > 40) begin
                total++; bad++;
                $display("FAIL hready_timeout got=0 want=1 after %0d cycles", guard);
                break;
            end
        end
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            total++;
            if (c_rdata() !== e.data) begin
                bad++;
                $display("FAIL %s hrdata got=%h want=%h", e.name, c_rdata(), e.data);
            end
            total++;
            if (c_resp() !== e.resp) begin
                bad++;
                $display("FAIL %s hresp got=%b want=%b", e.name, c_resp(), e.resp);
            end
            total++;
            if (lows !== e.lows) begin
                bad++;
                $display("FAIL %s wait_cycles got=%0d want=%0d", e.name, lows, e.lows);
            end
        end
        @(posedge HCLK); #1;
    endtask

    // Issue one address phase; the expected data-phase result goes on the queue.
    task automatic xfer(input string nm, input bit wr, input logic [2:0] sz,
                        input logic [15:0] a, input logic [31:0] wd,
                        input logic [1:0] tr = 2'b10, input bit s = 1'b1);
        exp_t       e;
        bit         err;
        logic [3:0] be;
        hsel0  = s && (cd == 0);
        hsel3  = s && (cd == 1);
        HTRANS = tr;
        HWRITE = wr;
        HSIZE  = sz;
        HADDR  = a;
        step();
        HWDATA = wd;
        e.name = nm; e.data = 32'h0; e.resp = 1'b0; e.lows = 0;
        if (s && tr[1]) begin
            err = (sz > 3'd2) || (sz == 3'd1 && a[0]) ||
                  (sz == 3'd2 && a[1:0] != 2'b00) || (a >= 16'h0400);
            if (err) begin
                e.resp = 1'b1;
                e.lows = 1;
            end else begin
                e.lows = (cd == 0) ? 0 : 3;
                if (wr) begin
                    be = (sz == 3'd0) ? (4'b0001 << a[1:0]) :
                         (sz == 3'd1) ? (4'b0011 << a[1:0]) : 4'b1111;
                    for (int i = 0; i < 4; i++)
                        if (be[i]) mdl[cd][a[9:2]][8*i +: 8] = wd[8*i +: 8];
                end else begin
                    e.data = mdl[cd][a[9:2]];
                end
            end
        end
        sbq.push_back(e);
    endtask

    task automatic flush();
        xfer("idle", 1'b0, 3'd0, 16'h0000, 32'h0, 2'b00);
        step();
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; hsel0 = 1'b0; hsel3 = 1'b0; HTRANS = 2'b00;
        HADDR = '0; HWDATA = '0; HWRITE = 1'b0; HSIZE = 3'd0;
        #2;
        total++; if (rdy0 !== 1'b1)    begin bad++; $display("FAIL rst_rdy0 got=%b want=1", rdy0); end
        total++; if (resp0 !== 1'b0)   begin bad++; $display("FAIL rst_resp0 got=%b want=0", resp0); end
        total++; if (rdata0 !== 32'h0) begin bad++; $display("FAIL rst_rdata0 got=%h want=0", rdata0); end
        total++; if (rdy3 !== 1'b1)    begin bad++; $display("FAIL rst_rdy3 got=%b want=1", rdy3); end
        total++; if (resp3 !== 1'b0)   begin bad++; $display("FAIL rst_resp3 got=%b want=0", resp3); end
        total++; if (rdata3 !== 32'h0) begin bad++; $display("FAIL rst_rdata3 got=%h want=0", rdata3); end
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
    endtask

    task automatic test_word_rw();
        cd = 0;
        xfer("w_deadbeef", 1'b1, 3'd2, 16'h0010, 32'hDEADBEEF);
        xfer("r_deadbeef", 1'b0, 3'd2, 16'h0010, 32'h0);
        flush();
    endtask

    task automatic test_byte_lanes();
        cd = 0;
        xfer("w_zero",  1'b1, 3'd2, 16'h0020, 32'h00000000);
        xfer("w_byte",  1'b1, 3'd0, 16'h0021, 32'h0000AA00);
        xfer("w_half",  1'b1, 3'd1, 16'h0022, 32'h55660000);
        xfer("r_lanes", 1'b0, 3'd2, 16'h0020, 32'h0);
        xfer("w_b3",    1'b1, 3'd0, 16'h0023, 32'h77000000);
        xfer("w_h0",    1'b1, 3'd1, 16'h0020, 32'h00001234);
        xfer("r_lanes2",1'b0, 3'd2, 16'h0020, 32'h0);
        flush();
    endtask

    task automatic test_wait_states();
        cd = 1;
        xfer("ws_w",  1'b1, 3'd2, 16'h0040, 32'h12345678);
        xfer("ws_r",  1'b0, 3'd2, 16'h0040, 32'h0);
        xfer("ws_wb", 1'b1, 3'd0, 16'h0042, 32'h00CD0000);
        xfer("ws_r2", 1'b0, 3'd2, 16'h0040, 32'h0);
        flush();
    endtask

    task automatic test_errors();
        cd = 0;
        xfer("e_init",  1'b1, 3'd2, 16'h0000, 32'h11223344);
        xfer("e_half",  1'b1, 3'd1, 16'h0001, 32'hFFFFFFFF);
        xfer("e_word",  1'b1, 3'd2, 16'h0002, 32'hFFFFFFFF);
        xfer("e_size3", 1'b1, 3'd3, 16'h0000, 32'hFFFFFFFF);
        xfer("e_oob",   1'b1, 3'd2, 16'h0400, 32'hFFFFFFFF);
        xfer("e_rdoob", 1'b0, 3'd2, 16'h0404, 32'h0);
        xfer("e_chk",   1'b0, 3'd2, 16'h0000, 32'h0);
        flush();
        cd = 1;
        xfer("e3_init", 1'b1, 3'd2, 16'h0004, 32'hA5A55A5A);
        xfer("e3_oob",  1'b1, 3'd2, 16'h0404, 32'h0BADF00D);
        xfer("e3_half", 1'b1, 3'd1, 16'h0005, 32'h0BADF00D);
        xfer("e3_chk",  1'b0, 3'd2, 16'h0004, 32'h0);
        flush();
    endtask

    task automatic test_no_access();
        cd = 0;
        xfer("na_busy",  1'b1, 3'd2, 16'h0010, 32'hBAD0BAD0, 2'b01);
        xfer("na_unsel", 1'b1, 3'd2, 16'h0010, 32'hBAD1BAD1, 2'b10, 1'b0);
        xfer("na_chk",   1'b0, 3'd2, 16'h0010, 32'h0);
        flush();
    endtask

    task automatic test_back_to_back();
        for (int d = 0; d < 2; d++) begin
            cd = d;
            for (int i = 0; i < 6; i++)
                xfer("b2b_w", 1'b1, 3'd2, 16'(16'h0100 + 4*i), $urandom);
            for (int i = 0; i < 6; i++) begin
                xfer("b2b_wh", 1'b1, 3'd1, 16'(16'h0102 + 4*i), $urandom);
                xfer("b2b_r",  1'b0, 3'd2, 16'(16'h0100 + 4*i), 32'h0);
            end
            flush();
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] keep;
        cd = 1;
        xfer("rm_pre", 1'b1, 3'd2, 16'h0030, 32'hCAFEF00D);
        flush();
        keep = mdl[1][12];
        xfer("rm_wr", 1'b1, 3'd2, 16'h0030, 32'h0D15EA5E);
        hsel3 = 1'b0; HTRANS = 2'b00;
        @(negedge HCLK);
        total++; if (rdy3 !== 1'b0) begin bad++; $display("FAIL rm_in_wait rdy got=%b want=0", rdy3); end
        #2;
        HRESETn = 1'b0;
        #1;
        total++; if (rdy3 !== 1'b1)    begin bad++; $display("FAIL rm_rdy got=%b want=1", rdy3); end
        total++; if (resp3 !== 1'b0)   begin bad++; $display("FAIL rm_resp got=%b want=0", resp3); end
        total++; if (rdata3 !== 32'h0) begin bad++; $display("FAIL rm_rdata got=%h want=0", rdata3); end
        sbq.delete();
        mdl[1][12] = keep;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        xfer("rm_chk", 1'b0, 3'd2, 16'h0030, 32'h0);
        flush();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_wait_states();
        test_errors();
        test_no_access();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
